// File: rtl/blink_rate_pkg.sv
// rtl/blink_rate_pkg.sv - shared blink half-period constants, rate codes and window bounds
//
// Ports: none (package).
//   NOM_*HZ      nominal clocks per half-period at 50 kHz, shared with the blinker
//   CODE_*HZ     2-bit rate codes in {sw1,sw2} order
//   win_lo/hi    inclusive acceptance bounds nominal -/+ (nominal >> tol_shift)
package blink_rate_pkg;

    localparam int NOM_100HZ = 250;
    localparam int NOM_50HZ  = 500;
    localparam int NOM_10HZ  = 2500;
    localparam int NOM_1HZ   = 25000;

    typedef logic [1:0] rate_code_t;

    localparam rate_code_t CODE_100HZ = 2'b00;
    localparam rate_code_t CODE_50HZ  = 2'b01;
    localparam rate_code_t CODE_10HZ  = 2'b10;
    localparam rate_code_t CODE_1HZ   = 2'b11;

    function automatic int win_lo(input int nominal, input int tol_shift);
        return nominal - (nominal >> tol_shift);
    endfunction

    function automatic int win_hi(input int nominal, input int tol_shift);
        return nominal + (nominal >> tol_shift);
    endfunction

endpackage

// File: rtl/led_edge_sync.sv
// rtl/led_edge_sync.sv - two-flop synchronizer with delay flop and any-polarity edge pulse
//
// Ports:
//   clk       system clock
//   rst_n     synchronous reset, active-low
//   led       asynchronous blink input
//   level     synchronized level (second sync flop)
//   edge_det  one-cycle pulse on either polarity of the synchronized level
module led_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic led,
    output logic level,
    output logic edge_det
);

    logic sync1;
    logic sync2;
    logic dly;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= led;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign level    = sync2;
    assign edge_det = sync2 ^ dly;

endmodule

// File: rtl/blink_rate_decoder.sv
// rtl/blink_rate_decoder.sv - measures LED edge spacing and decodes the blinker rate code
//
// Ports:
//   i_clk     system clock (50 kHz nominal)
//   i_rst_n   synchronous reset, active-low
//   i_led     asynchronous blink input
//   o_code    decoded rate: 00=100Hz, 01=50Hz, 10=10Hz, 11=1Hz
//   o_valid   o_code confirmed by MATCH_N consecutive matching half-periods
//   o_lost    no edge seen for TIMEOUT clocks
//   o_level   synchronized level of i_led
module blink_rate_decoder
    import blink_rate_pkg::*;
#(
    parameter int C_CNT_100HZ = NOM_100HZ,
    parameter int C_CNT_50HZ  = NOM_50HZ,
    parameter int C_CNT_10HZ  = NOM_10HZ,
    parameter int C_CNT_1HZ   = NOM_1HZ,
    parameter int TOL_SHIFT   = 3,
    parameter int MATCH_N     = 4,
    parameter int TIMEOUT     = 2 * C_CNT_1HZ
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_led,
    output logic [1:0] o_code,
    output logic       o_valid,
    output logic       o_lost,
    output logic       o_level
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MATCH_N + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_FULL = SW'(MATCH_N);

    // Index order matches the code value, so bin k reports code k.
    localparam int WIN_LO [4] = '{win_lo(C_CNT_100HZ, TOL_SHIFT), win_lo(C_CNT_50HZ, TOL_SHIFT),
                                  win_lo(C_CNT_10HZ, TOL_SHIFT),  win_lo(C_CNT_1HZ, TOL_SHIFT)};
    localparam int WIN_HI [4] = '{win_hi(C_CNT_100HZ, TOL_SHIFT), win_hi(C_CNT_50HZ, TOL_SHIFT),
                                  win_hi(C_CNT_10HZ, TOL_SHIFT),  win_hi(C_CNT_1HZ, TOL_SHIFT)};

    logic            edge_det;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   streak;
    logic            armed;
    rate_code_t      prev_bin;

    int              spacing;
    logic            in_bin;
    rate_code_t      bin;
    logic [SW-1:0]   streak_nxt;

    led_edge_sync u_sync (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .led      (i_led),
        .level    (o_level),
        .edge_det (edge_det)
    );

    // Spacing is counter+1: the counter was zeroed on the previous edge cycle,
    // so an input toggling every N clocks measures exactly N.
    always_comb begin
        spacing = int'(cnt) + 1;
        in_bin  = 1'b0;
        bin     = CODE_100HZ;
        for (int k = 0; k < 4; k++) begin
            if (spacing >= WIN_LO[k] && spacing <= WIN_HI[k]) begin
                in_bin = 1'b1;
                bin    = rate_code_t'(k);
            end
        end
    end

    always_comb begin
        streak_nxt = SW'(1);
        if (bin == prev_bin) begin
            streak_nxt = (streak == STREAK_FULL) ? STREAK_FULL : streak + SW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            streak   <= '0;
            armed    <= 1'b0;
            prev_bin <= CODE_100HZ;
            o_code   <= CODE_100HZ;
            o_valid  <= 1'b0;
            o_lost   <= 1'b0;
        end else if (edge_det) begin
            // An edge always wins over a coincident timeout.
            cnt    <= '0;
            o_lost <= 1'b0;
            if (!armed) begin
                // First edge after reset or loss has no valid reference spacing.
                armed  <= 1'b1;
                streak <= '0;
            end else if (in_bin) begin
                prev_bin <= bin;
                streak   <= streak_nxt;
                if (streak_nxt == STREAK_FULL) begin
                    o_valid <= 1'b1;
                    o_code  <= bin;
                end else begin
                    o_valid <= 1'b0;
                end
            end else begin
                streak  <= '0;
                o_valid <= 1'b0;
            end
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
                o_lost  <= 1'b1;
                o_valid <= 1'b0;
                armed   <= 1'b0;
                streak  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// tb/tb_blink_rate_decoder.sv - directed self-checking bench for blink_rate_decoder
module tb_blink_rate_decoder;

    localparam int TB_1HZ    = 5000;
    localparam int TB_TMO    = 2 * TB_1HZ;

    logic       clk;
    logic       rst_n;
    logic       led;
    logic [1:0] code;
    logic       valid;
    logic       lost;
    logic       level;

    int errors = 0;
    int checks = 0;

    blink_rate_decoder #(
        .C_CNT_100HZ (250),
        .C_CNT_50HZ  (500),
        .C_CNT_10HZ  (2500),
        .C_CNT_1HZ   (TB_1HZ),
        .TOL_SHIFT   (3),
        .MATCH_N     (4),
        .TIMEOUT     (TB_TMO)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_led   (led),
        .o_code  (code),
        .o_valid (valid),
        .o_lost  (lost),
        .o_level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        clks(n);
        led = ~led;
    endtask

    task automatic chk(input string tag, input logic exp_valid, input logic [1:0] exp_code,
                       input logic exp_lost);
        checks++;
        assert ({valid, code, lost} === {exp_valid, exp_code, exp_lost})
        else begin
            errors++;
            $error("FAIL %s observed valid=%b code=%b lost=%b expected valid=%b code=%b lost=%b",
                   tag, valid, code, lost, exp_valid, exp_code, exp_lost);
        end
    endtask

    task automatic chk_level(input string tag, input logic exp_level);
        checks++;
        assert (level === exp_level)
        else begin
            errors++;
            $error("FAIL %s observed level=%b expected level=%b", tag, level, exp_level);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        led   = 1'b0;
        clks(3);
        chk("reset_outputs", 1'b0, 2'b00, 1'b0);
        chk_level("reset_level", 1'b0);
        rst_n = 1'b1;

        // 100 Hz: arming edge plus four 250-clock spacings.
        gap(10);
        clks(2);
        chk_level("level_follows", 1'b1);
        gap(248);
        gap(250);
        gap(250);
        clks(3);
        chk("100hz_edge4", 1'b0, 2'b00, 1'b0);
        gap(247);
        clks(2);
        chk("100hz_edge5_minus1", 1'b0, 2'b00, 1'b0);
        clks(1);
        chk("100hz_lock", 1'b1, 2'b00, 1'b0);

        // One-clock glitch 100 clocks after the last clean edge.
        gap(97);
        gap(1);
        clks(2);
        chk("glitch_drop", 1'b0, 2'b00, 1'b0);
        gap(147);
        gap(250);
        gap(250);
        gap(250);
        clks(3);
        chk("glitch_relock_3", 1'b0, 2'b00, 1'b0);
        gap(247);
        clks(3);
        chk("glitch_relock_4", 1'b1, 2'b00, 1'b0);

        // 1 Hz (scaled) takes over from 100 Hz.
        gap(TB_1HZ - 3);
        clks(3);
        chk("to_1hz_drop", 1'b0, 2'b00, 1'b0);
        gap(TB_1HZ - 3);
        gap(TB_1HZ);
        gap(TB_1HZ);
        clks(3);
        chk("1hz_lock", 1'b1, 2'b11, 1'b0);

        // Mid-stream switch to 50 Hz.
        gap(497);
        clks(2);
        chk("to_50hz_minus1", 1'b1, 2'b11, 1'b0);
        clks(1);
        chk("to_50hz_drop", 1'b0, 2'b11, 1'b0);
        gap(497);
        gap(500);
        clks(3);
        chk("50hz_streak3", 1'b0, 2'b11, 1'b0);
        gap(497);
        clks(3);
        chk("50hz_lock", 1'b1, 2'b01, 1'b0);

        // One-clock reset mid-lock.
        clks(100);
        rst_n = 1'b0;
        led   = 1'b0;
        clks(1);
        chk("midlock_reset", 1'b0, 2'b00, 1'b0);
        chk_level("midlock_reset_level", 1'b0);
        rst_n = 1'b1;
        gap(20);
        gap(500);
        gap(500);
        gap(500);
        clks(3);
        chk("post_reset_edge4", 1'b0, 2'b00, 1'b0);
        gap(497);
        clks(3);
        chk("post_reset_edge5", 1'b1, 2'b01, 1'b0);

        // 10 Hz window boundaries.
        gap(2497);
        gap(2812);
        gap(2188);
        clks(3);
        chk("10hz_streak3", 1'b0, 2'b01, 1'b0);
        gap(2497);
        clks(3);
        chk("10hz_window_lock", 1'b1, 2'b10, 1'b0);
        gap(2810);
        clks(2);
        chk("10hz_2813_minus1", 1'b1, 2'b10, 1'b0);
        clks(1);
        chk("10hz_2813_reject", 1'b0, 2'b10, 1'b0);

        // Re-lock at 10 Hz, then stop toggling.
        gap(2497);
        gap(2500);
        gap(2500);
        gap(2500);
        clks(3);
        chk("10hz_relock", 1'b1, 2'b10, 1'b0);
        clks(TB_TMO - 1);
        chk("timeout_minus1", 1'b1, 2'b10, 1'b0);
        clks(1);
        chk("timeout_lost", 1'b0, 2'b10, 1'b1);
        gap(50);
        clks(2);
        chk("lost_held", 1'b0, 2'b10, 1'b1);
        clks(1);
        chk("lost_cleared", 1'b0, 2'b10, 1'b0);
        gap(247);
        gap(250);
        gap(250);
        clks(3);
        chk("after_loss_edge4", 1'b0, 2'b10, 1'b0);
        gap(247);
        clks(3);
        chk("after_loss_lock", 1'b1, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
